// File: rtl/fir_sweep_pkg.sv
// Package: fir_sweep_pkg
// Shared definitions for the frequency-sweep controller and its peak-to-peak
// tracker: the sweep state encoding, default widths, and helpers that give
// the signed extremes of a FILTERED_WIDTH-wide two's complement value.
package fir_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    REPORT  = 3'd3,
    DONE    = 3'd4
  } sweep_state_t;

  localparam int DEFAULT_PHASE_STEP_WIDTH = 32;
  localparam int DEFAULT_FILTERED_WIDTH   = 32;
  localparam int DEFAULT_COUNT_WIDTH      = 16;

  // Bit patterns of the most positive / most negative value of a signed
  // number 'width' bits wide (width <= 64); callers truncate to width.
  function automatic logic [63:0] signed_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] signed_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/fir_sweep_controller_peak_to_peak_tracker.sv
// Module: peak_to_peak_tracker
// Tracks the signed maximum and minimum of a sample stream and presents the
// peak-to-peak amplitude, including the sample offered in the current cycle,
// so the owner can capture a complete result on the edge of the last sample.
// Ports:
//   clock, reset_n   single clock, synchronous active-low reset
//   clear            re-arm: max <= most negative, min <= most positive
//   sample           signed two's complement sample
//   sample_valid     sample participates in max/min this cycle
//   amplitude        max-min (unsigned, WIDTH+1 bits, never overflows)
module peak_to_peak_tracker
  import fir_sweep_pkg::*;
#(
  parameter int WIDTH = DEFAULT_FILTERED_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic [WIDTH:0]   amplitude
);

  localparam logic [WIDTH-1:0] MOST_POS = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(signed_min(WIDTH));

  logic signed [WIDTH-1:0] max_reg, min_reg;
  logic signed [WIDTH-1:0] max_next, min_next;

  always_comb begin
    max_next = max_reg;
    min_next = min_reg;
    if (sample_valid) begin
      if ($signed(sample) > max_reg) max_next = $signed(sample);
      if ($signed(sample) < min_reg) min_next = $signed(sample);
    end
  end

  // Sign-extend both extremes by one bit; the difference then fits unsigned.
  assign amplitude = {max_next[WIDTH-1], max_next} - {min_next[WIDTH-1], min_next};

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      max_reg <= MOST_NEG;
      min_reg <= MOST_POS;
    end else begin
      max_reg <= max_next;
      min_reg <= min_next;
    end
  end

endmodule

// File: rtl/fir_sweep_controller.sv
// Module: fir_sweep_controller
// Frequency-sweep sequencer for a sine generator -> FIR filter chain. Steps
// the generator phase_step across a programmed range; per step it discards
// settle_samples filter outputs, measures the peak-to-peak amplitude over
// measure_samples outputs and reports {phase_step, amplitude} on a
// valid/ready stream.
// Ports:
//   clock, reset_n                      single clock, synchronous active-low reset
//   start, abort                        sweep control pulses (abort wins)
//   start_phase_step, phase_increment,
//   number_of_steps, settle_samples,
//   measure_samples                     sweep configuration, latched on start
//   phase_step, generator_enable        generator control
//   filtered_data, filtered_data_valid  filter output stream
//   result_phase_step, result_amplitude,
//   result_valid, result_ready          result stream
//   busy, done                          status (done = 1-cycle completion pulse)
module fir_sweep_controller
  import fir_sweep_pkg::*;
#(
  parameter int PHASE_STEP_WIDTH = DEFAULT_PHASE_STEP_WIDTH,
  parameter int FILTERED_WIDTH   = DEFAULT_FILTERED_WIDTH,
  parameter int COUNT_WIDTH      = DEFAULT_COUNT_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [PHASE_STEP_WIDTH-1:0] start_phase_step,
  input  logic [PHASE_STEP_WIDTH-1:0] phase_increment,
  input  logic [COUNT_WIDTH-1:0]      number_of_steps,
  input  logic [COUNT_WIDTH-1:0]      settle_samples,
  input  logic [COUNT_WIDTH-1:0]      measure_samples,
  output logic [PHASE_STEP_WIDTH-1:0] phase_step,
  output logic                        generator_enable,
  input  logic [FILTERED_WIDTH-1:0]   filtered_data,
  input  logic                        filtered_data_valid,
  output logic [PHASE_STEP_WIDTH-1:0] result_phase_step,
  output logic [FILTERED_WIDTH:0]     result_amplitude,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        busy,
  output logic                        done
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  sweep_state_t state, state_next;

  logic [PHASE_STEP_WIDTH-1:0] increment_cfg;
  logic [COUNT_WIDTH-1:0]      steps_cfg, settle_cfg, measure_cfg;
  logic [COUNT_WIDTH-1:0]      step_cnt, settle_cnt, measure_cnt;
  logic [COUNT_WIDTH-1:0]      measure_target;
  logic                        settle_last, measure_last, last_step;
  logic                        start_accept, handshake;
  logic                        busy_next, generator_enable_next, done_next, result_valid_next;
  logic [FILTERED_WIDTH:0]     tracker_amplitude;

  // A zero measure length still measures one sample.
  assign measure_target = (measure_cfg == '0) ? CNT_ONE : measure_cfg;
  assign settle_last    = (settle_cfg == '0) ||
                          (filtered_data_valid && (settle_cnt == settle_cfg - CNT_ONE));
  assign measure_last   = filtered_data_valid && (measure_cnt == measure_target - CNT_ONE);
  assign last_step      = (step_cnt + CNT_ONE) == steps_cfg;
  assign start_accept   = (state == IDLE) && start && !abort;
  assign handshake      = (state == REPORT) && result_ready && !abort;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (number_of_steps == '0) ? DONE : SETTLE;
      SETTLE:  if (settle_last) state_next = MEASURE;
      MEASURE: if (measure_last) state_next = REPORT;
      REPORT:  if (result_ready) state_next = last_step ? DONE : SETTLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Output decode from the upcoming state so status outputs can be registered
  // and still line up with the state they describe.
  always_comb begin
    busy_next             = (state_next != IDLE);
    generator_enable_next = (state_next == SETTLE) || (state_next == MEASURE) ||
                            (state_next == REPORT);
    done_next             = (state_next == DONE);
    result_valid_next     = (state_next == REPORT);
  end

  peak_to_peak_tracker #(
    .WIDTH (FILTERED_WIDTH)
  ) u_tracker (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        ((state == SETTLE) && (state_next == MEASURE)),
    .sample       (filtered_data),
    .sample_valid ((state == MEASURE) && filtered_data_valid),
    .amplitude    (tracker_amplitude)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy              <= 1'b0;
      generator_enable  <= 1'b0;
      done              <= 1'b0;
      result_valid      <= 1'b0;
      result_phase_step <= '0;
      result_amplitude  <= '0;
      phase_step        <= '0;
      increment_cfg     <= '0;
      steps_cfg         <= '0;
      settle_cfg        <= '0;
      measure_cfg       <= '0;
      step_cnt          <= '0;
      settle_cnt        <= '0;
      measure_cnt       <= '0;
    end else begin
      busy             <= busy_next;
      generator_enable <= generator_enable_next;
      done             <= done_next;
      result_valid     <= result_valid_next;

      if (start_accept) begin
        phase_step    <= start_phase_step;
        increment_cfg <= phase_increment;
        steps_cfg     <= number_of_steps;
        settle_cfg    <= settle_samples;
        measure_cfg   <= measure_samples;
        step_cnt      <= '0;
      end

      // Sample counters only advance on valid samples and rest at zero
      // outside their own state, so every step starts from a clean count.
      if (state == SETTLE) begin
        if (filtered_data_valid) settle_cnt <= settle_cnt + CNT_ONE;
      end else begin
        settle_cnt <= '0;
      end

      if (state == MEASURE) begin
        if (filtered_data_valid) measure_cnt <= measure_cnt + CNT_ONE;
      end else begin
        measure_cnt <= '0;
      end

      // Capture on the last measured sample; the tracker amplitude already
      // includes it.
      if ((state == MEASURE) && (state_next == REPORT)) begin
        result_phase_step <= phase_step;
        result_amplitude  <= tracker_amplitude;
      end

      if (handshake) begin
        step_cnt <= step_cnt + CNT_ONE;
        if (!last_step) phase_step <= phase_step + increment_cfg;
      end
    end
  end

endmodule

// File: tb/tb_fir_sweep_controller.sv
// Testbench: tb_fir_sweep_controller
// Directed sequence with a result scoreboard: expected {phase_step, amplitude}
// pairs are queued when a sweep is launched and compared by a monitor on every
// accepted result.
module tb_fir_sweep_controller;

  localparam int PW = 32;
  localparam int FW = 32;
  localparam int CW = 16;
  localparam logic [FW-1:0] POS_K = 32'd1000;
  localparam logic [FW-1:0] NEG_K = 32'hFFFF_FC18;  // -1000

  logic          clock = 1'b0;
  logic          reset_n, start, abort;
  logic [PW-1:0] start_phase_step, phase_increment;
  logic [CW-1:0] number_of_steps, settle_samples, measure_samples;
  logic [PW-1:0] phase_step;
  logic          generator_enable;
  logic [FW-1:0] filtered_data, direct_data, alt_data;
  logic          filtered_data_valid, alt_mode;
  logic [PW-1:0] result_phase_step;
  logic [FW:0]   result_amplitude;
  logic          result_valid, result_ready, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int done_count = 0;
  int result_count = 0;

  typedef struct packed {
    logic [PW-1:0] ph;
    logic [FW:0]   amp;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  // Filter stand-in: either a directly driven value or a +/-1000 square wave
  // that toggles every cycle (any two consecutive samples span 2000).
  assign filtered_data = alt_mode ? alt_data : direct_data;

  fir_sweep_controller #(
    .PHASE_STEP_WIDTH (PW),
    .FILTERED_WIDTH   (FW),
    .COUNT_WIDTH      (CW)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .start               (start),
    .abort               (abort),
    .start_phase_step    (start_phase_step),
    .phase_increment     (phase_increment),
    .number_of_steps     (number_of_steps),
    .settle_samples      (settle_samples),
    .measure_samples     (measure_samples),
    .phase_step          (phase_step),
    .generator_enable    (generator_enable),
    .filtered_data       (filtered_data),
    .filtered_data_valid (filtered_data_valid),
    .result_phase_step   (result_phase_step),
    .result_amplitude    (result_amplitude),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .busy                (busy),
    .done                (done)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_sweep(input logic [PW-1:0] sp, input logic [PW-1:0] inc,
                             input logic [CW-1:0] n, input logic [CW-1:0] s,
                             input logic [CW-1:0] m);
    start_phase_step = sp;
    phase_increment  = inc;
    number_of_steps  = n;
    settle_samples   = s;
    measure_samples  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [FW-1:0] v);
    direct_data = v;
    filtered_data_valid = 1'b1;
    tick();
    filtered_data_valid = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic wait_valid(input string tag, input int budget, output int k);
    k = 0;
    while (!result_valid && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(result_valid), 64'd1);
  endtask

  task automatic expect_result(input logic [PW-1:0] ph, input logic [FW:0] amp);
    exp_t e;
    e.ph  = ph;
    e.amp = amp;
    sb.push_back(e);
  endtask

  // Monitor: one line per accepted result, compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done) done_count++;
      if (result_valid && result_ready) begin
        result_count++;
        $display("result %0d: phase_step=%h amplitude=%h", result_count,
                 result_phase_step, result_amplitude);
        check("result_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result_phase_step", 64'(result_phase_step), 64'(e.ph));
          check("result_amplitude", 64'(result_amplitude), 64'(e.amp));
        end
      end
    end
  end

  initial begin
    alt_data = POS_K;
    forever begin
      @(posedge clock);
      #1;
      alt_data = (alt_data == POS_K) ? NEG_K : POS_K;
    end
  end

  initial begin
    int k, d0, r0;

    // Reset held with start asserted: nothing may launch.
    reset_n = 1'b0; start = 1'b1; abort = 1'b0;
    start_phase_step = 32'd888; phase_increment = 32'd1;
    number_of_steps = 16'd3; settle_samples = 16'd0; measure_samples = 16'd1;
    direct_data = '0; filtered_data_valid = 1'b0; alt_mode = 1'b0; result_ready = 1'b0;
    tick(10);
    check("rst_phase_step", 64'(phase_step), 64'd0);
    check("rst_generator_enable", 64'(generator_enable), 64'd0);
    check("rst_result_phase_step", 64'(result_phase_step), 64'd0);
    check("rst_result_amplitude", 64'(result_amplitude), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    start = 1'b0;
    reset_n = 1'b1;
    tick();

    // Three-step sweep, valid tied high.
    alt_mode = 1'b1; filtered_data_valid = 1'b1; result_ready = 1'b1;
    expect_result(32'd888,       33'd2000);
    expect_result(32'h0010_0378, 33'd2000);
    expect_result(32'h0020_0378, 33'd2000);
    d0 = done_count; r0 = result_count;
    start_sweep(32'd888, 32'h0010_0000, 16'd3, 16'd4, 16'd8);
    check("sweep_busy", 64'(busy), 64'd1);
    check("sweep_gen_enable", 64'(generator_enable), 64'd1);
    check("sweep_phase_first", 64'(phase_step), 64'd888);
    wait_valid("sweep_first_valid", 40, k);
    check("sweep_first_latency", 64'(k), 64'd12);
    wait_not_busy("sweep_finish", 200);
    check("sweep_done_pulses", 64'(done_count - d0), 64'd1);
    check("sweep_result_count", 64'(result_count - r0), 64'd3);
    check("sweep_phase_hold", 64'(phase_step), 64'h0020_0378);
    check("sweep_gen_enable_off", 64'(generator_enable), 64'd0);
    check("sweep_sb_empty", 64'(sb.size()), 64'd0);

    // phase_step wrap.
    alt_mode = 1'b0; direct_data = 32'd5;
    expect_result(32'hFFF0_0000, 33'd0);
    expect_result(32'h0010_0000, 33'd0);
    start_sweep(32'hFFF0_0000, 32'h0020_0000, 16'd2, 16'd0, 16'd1);
    wait_not_busy("wrap_finish", 100);
    check("wrap_sb_empty", 64'(sb.size()), 64'd0);

    // Amplitude with valid gaps, plus a start and config change mid-sweep.
    filtered_data_valid = 1'b0;
    expect_result(32'd1234, 33'd350);
    start_sweep(32'd1234, 32'd1, 16'd1, 16'd0, 16'd4);
    tick(3);
    start_phase_step = 32'd999; measure_samples = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored_phase", 64'(phase_step), 64'd1234);
    check("busy_start_still_busy", 64'(busy), 64'd1);
    feed(32'd100);
    feed(32'hFFFF_FFCE);  // -50
    tick(2);
    feed(32'd300);
    feed(32'hFFFF_FFF9);  // -7
    wait_not_busy("amp350_finish", 50);

    expect_result(32'd7, 33'd4);
    start_sweep(32'd7, 32'd0, 16'd1, 16'd0, 16'd2);
    tick(2);
    feed(32'hFFFF_FFFB);  // -5
    feed(32'hFFFF_FFF7);  // -9
    wait_not_busy("amp4_finish", 50);

    expect_result(32'd8, 33'h0_FFFF_FFFF);
    start_sweep(32'd8, 32'd0, 16'd1, 16'd0, 16'd2);
    tick(2);
    feed(32'h7FFF_FFFF);
    feed(32'h8000_0000);
    wait_not_busy("ampmax_finish", 50);

    // measure_samples == 0 measures a single sample.
    expect_result(32'd9, 33'd0);
    start_sweep(32'd9, 32'd0, 16'd1, 16'd0, 16'd0);
    tick(2);
    feed(32'd42);
    wait_not_busy("meas0_finish", 50);
    check("amp_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: result and phase_step frozen while ready is low.
    alt_mode = 1'b1; filtered_data_valid = 1'b1; result_ready = 1'b0;
    expect_result(32'd500, 33'd2000);
    expect_result(32'd600, 33'd2000);
    start_sweep(32'd500, 32'd100, 16'd2, 16'd2, 16'd3);
    wait_valid("bp_first_valid", 40, k);
    for (int i = 0; i < 20; i++) begin
      check("bp_valid_held", 64'(result_valid), 64'd1);
      check("bp_result_phase", 64'(result_phase_step), 64'd500);
      check("bp_result_amp", 64'(result_amplitude), 64'd2000);
      check("bp_phase_step", 64'(phase_step), 64'd500);
      tick();
    end
    result_ready = 1'b1;
    tick();
    check("bp_valid_drop", 64'(result_valid), 64'd0);
    check("bp_next_phase", 64'(phase_step), 64'd600);
    wait_not_busy("bp_finish", 100);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Abort in MEASURE: idle next cycle, no result, no done.
    alt_mode = 1'b0; filtered_data_valid = 1'b0;
    d0 = done_count; r0 = result_count;
    start_sweep(32'd77, 32'd0, 16'd1, 16'd0, 16'd8);
    tick(3);
    feed(32'd1);
    feed(32'd2);
    feed(32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_gen_enable", 64'(generator_enable), 64'd0);
    check("abort_result_valid", 64'(result_valid), 64'd0);
    filtered_data_valid = 1'b1;
    tick(20);
    filtered_data_valid = 1'b0;
    check("abort_no_result", 64'(result_count - r0), 64'd0);
    check("abort_no_done", 64'(done_count - d0), 64'd0);

    // abort and start together: abort wins.
    number_of_steps = 16'd1;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'd0);
    check("abort_start_gen_enable", 64'(generator_enable), 64'd0);

    // Zero-step sweep: done pulse only.
    d0 = done_count; r0 = result_count;
    start_sweep(32'd55, 32'd0, 16'd0, 16'd0, 16'd1);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd1);
    check("zero_gen_enable", 64'(generator_enable), 64'd0);
    check("zero_phase", 64'(phase_step), 64'd55);
    tick();
    check("zero_done_drop", 64'(done), 64'd0);
    check("zero_busy_drop", 64'(busy), 64'd0);
    tick(3);
    check("zero_done_pulses", 64'(done_count - d0), 64'd1);
    check("zero_no_result", 64'(result_count - r0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
